// File: rtl/mvm_controller_pkg.sv
// Shared definitions for the matrix-vector multiply controller:
// state encodings, default geometry and an address-width helper.
package mvm_controller_pkg;

  localparam int unsigned DEF_ROWS   = 4;
  localparam int unsigned DEF_COLS   = 4;
  localparam int unsigned DEF_RD_LAT = 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACCUM = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Width needed to index n items; never below 1 bit.
  function automatic int unsigned aw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mvm_controller_delay_line.sv
// mvm_delay_line: 1-bit shift register, async active-high reset.
// Ports: clk, rst, d (in), q (out) = d delayed DEPTH cycles.
module mvm_delay_line #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  // Shift in at bit 0; the cast drops the bit that falls off the top.
  always_comb begin
    sr_d = DEPTH'({sr_q, d});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/mvm_controller.sv
// mvm_controller: control FSM for the matrix-vector multiply unit.
// Ports: clk, rst (async, high), start in; done, busy, rd_en,
//   mat_addr, vec_addr, acc_clr, acc_en, res_wr_en, res_addr out.
module mvm_controller
  import mvm_controller_pkg::*;
#(
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned RD_LAT = DEF_RD_LAT,
  parameter int unsigned MAT_AW = aw(ROWS * COLS),
  parameter int unsigned VEC_AW = aw(COLS),
  parameter int unsigned RES_AW = aw(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  output logic              busy,
  output logic              rd_en,
  output logic [MAT_AW-1:0] mat_addr,
  output logic [VEC_AW-1:0] vec_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              res_wr_en,
  output logic [RES_AW-1:0] res_addr
);

  localparam int unsigned DC_W = aw(RD_LAT);
  localparam logic [VEC_AW-1:0] COL_LAST = VEC_AW'(COLS - 1);
  localparam logic [RES_AW-1:0] ROW_LAST = RES_AW'(ROWS - 1);
  localparam logic [DC_W-1:0]   DC_LAST  = DC_W'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic [RES_AW-1:0] row_q, row_d;
  logic [VEC_AW-1:0] col_q, col_d;
  logic [DC_W-1:0]   dcnt_q, dcnt_d;

  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              rd_en_q, rd_en_d;
  logic              acc_clr_q, acc_clr_d;
  logic              res_wr_q, res_wr_d;
  logic [MAT_AW-1:0] mat_addr_q, mat_addr_d;
  logic [VEC_AW-1:0] vec_addr_q, vec_addr_d;
  logic [RES_AW-1:0] res_addr_q, res_addr_d;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          row_d   = '0;
        end
      end
      S_CLEAR: begin
        col_d   = '0;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        // col holds at the last column; only CLEAR rewinds it.
        if (col_q == COL_LAST) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DC_LAST) begin
          state_d = S_WRITE;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (row_q == ROW_LAST) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they
  // line up with the state they belong to and never see start directly.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    acc_clr_d  = (state_d == S_CLEAR);
    rd_en_d    = (state_d == S_ACCUM);
    res_wr_d   = (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
    mat_addr_d = '0;
    vec_addr_d = '0;
    res_addr_d = '0;
    if (rd_en_d) begin
      mat_addr_d = MAT_AW'(row_d) * MAT_AW'(COLS) + MAT_AW'(col_d);
      vec_addr_d = col_d;
    end
    if (res_wr_d) begin
      res_addr_d = row_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      dcnt_q     <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      acc_clr_q  <= 1'b0;
      res_wr_q   <= 1'b0;
      mat_addr_q <= '0;
      vec_addr_q <= '0;
      res_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      dcnt_q     <= dcnt_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      rd_en_q    <= rd_en_d;
      acc_clr_q  <= acc_clr_d;
      res_wr_q   <= res_wr_d;
      mat_addr_q <= mat_addr_d;
      vec_addr_q <= vec_addr_d;
      res_addr_q <= res_addr_d;
    end
  end

  // acc_en follows rd_en by the memory read latency.
  mvm_delay_line #(
    .DEPTH(RD_LAT)
  ) u_dly (
    .clk(clk),
    .rst(rst),
    .d  (rd_en_q),
    .q  (acc_en)
  );

  assign done      = done_q;
  assign busy      = busy_q;
  assign rd_en     = rd_en_q;
  assign acc_clr   = acc_clr_q;
  assign res_wr_en = res_wr_q;
  assign mat_addr  = mat_addr_q;
  assign vec_addr  = vec_addr_q;
  assign res_addr  = res_addr_q;

endmodule

// File: tb/tb_mvm_controller.sv
// Testbench for mvm_controller: scoreboard of expected strobes,
// with a small memory + MAC model to check the datapath sequencing.
module tb_mvm_controller;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int RD_LAT = 1;
  localparam int MAT_AW = 4;
  localparam int VEC_AW = 2;
  localparam int RES_AW = 2;
  localparam int P      = COLS + RD_LAT + 2;
  localparam int JOB    = ROWS * P;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic done, busy, rd_en, acc_clr, acc_en, res_wr_en;
  logic [MAT_AW-1:0] mat_addr;
  logic [VEC_AW-1:0] vec_addr;
  logic [RES_AW-1:0] res_addr;

  mvm_controller #(
    .ROWS(ROWS), .COLS(COLS), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .done(done), .busy(busy), .rd_en(rd_en),
    .mat_addr(mat_addr), .vec_addr(vec_addr),
    .acc_clr(acc_clr), .acc_en(acc_en),
    .res_wr_en(res_wr_en), .res_addr(res_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int mat [ROWS*COLS];
  int vec [COLS];
  int res_mem [ROWS];
  int exp_res [ROWS];
  int mdat, vdat, acc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdat <= 0;
      vdat <= 0;
      acc  <= 0;
    end else begin
      if (rd_en) begin
        mdat <= mat[mat_addr];
        vdat <= vec[vec_addr];
      end
      if (acc_clr) acc <= 0;
      else if (acc_en) acc <= acc + mdat * vdat;
      if (res_wr_en) res_mem[res_addr] <= acc;
    end
  end

  typedef struct {
    int kind;
    int cyc;
    int a;
    int b;
    int v;
  } ev_t;

  ev_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (cyc %0d)",
               nm, act, exp_v, cyc);
    end
  endfunction

  function automatic void push_job(input int s);
    for (int r = 0; r < ROWS; r++) begin
      q.push_back('{0, s + r*P, 0, 0, 0});
      for (int c = 0; c < COLS; c++)
        q.push_back('{1, s + r*P + 1 + c, r*COLS + c, c, 0});
      q.push_back('{2, s + r*P + P - 1, r, 0, exp_res[r]});
    end
    q.push_back('{3, s + JOB, ROWS*COLS, 0, 0});
  endfunction

  ev_t e;
  int k;
  int acc_cnt = 0;
  bit prev_done = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      acc_cnt   = 0;
      prev_done = 1'b0;
    end else begin
      if (acc_en) acc_cnt++;
      chk("acc_en_overlap", 32'(acc_en & (acc_clr | res_wr_en)), 0);
      if (done) chk("done_width", 32'(prev_done), 0);
      prev_done = done;
      if (acc_clr || rd_en || res_wr_en || done) begin
        k = done ? 3 : res_wr_en ? 2 : rd_en ? 1 : 0;
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious: kind %0d at cyc %0d, required none",
                   k, cyc);
        end else begin
          e = q.pop_front();
          chk("kind", k, e.kind);
          chk("cycle", cyc, e.cyc);
          chk("busy", 32'(busy), 1);
          case (e.kind)
            1: begin
              chk("mat_addr", 32'(mat_addr), e.a);
              chk("vec_addr", 32'(vec_addr), e.b);
            end
            2: begin
              chk("res_addr", 32'(res_addr), e.a);
              chk("acc_val", acc, e.v);
            end
            3: begin
              chk("acc_en_count", acc_cnt, e.a);
              acc_cnt = 0;
              for (int r = 0; r < ROWS; r++)
                chk("res_mem", res_mem[r], exp_res[r]);
            end
            default: ;
          endcase
        end
      end
    end
  end

  function automatic logic [31:0] outs();
    return 32'({busy, done, rd_en, acc_clr, acc_en, res_wr_en,
                mat_addr, vec_addr, res_addr});
  endfunction

  task automatic idle_chk(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      chk(nm, outs(), 0);
    end
  endtask

  task automatic wait_q(input string nm, input int bound);
    int i;
    i = 0;
    while (q.size() != 0 && i < bound) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: %0d events pending, required 0",
               nm, q.size());
      q.delete();
    end
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk);
    start = 1'b1;
    s = cyc + 1;
    push_job(s);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_diag();
    for (int i = 0; i < ROWS*COLS; i++)
      mat[i] = (i / COLS == i % COLS) ? 2 : 0;
    for (int c = 0; c < COLS; c++) vec[c] = c + 1;
    exp_res = '{2, 4, 6, 8};
  endtask

  task automatic load_ramp();
    for (int i = 0; i < ROWS*COLS; i++) mat[i] = i + 1;
    for (int c = 0; c < COLS; c++) vec[c] = c + 1;
    exp_res = '{30, 70, 110, 150};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    for (int r = 0; r < ROWS; r++) res_mem[r] = 0;
    load_diag();

    // T1: reset
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("t1_in_reset", outs(), 0);
    rst = 1'b0;
    idle_chk("t1_idle", 2);

    // T2/T3: single job, diagonal matrix
    pulse_start(s);
    wait_q("t2_job", JOB + 10);
    idle_chk("t2_idle", 2);

    // T4: start re-pulsed mid-job is ignored
    for (int r = 0; r < ROWS; r++) res_mem[r] = 0;
    pulse_start(s);
    while (cyc != s + 8) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_q("t4_job", JOB + 10);
    idle_chk("t4_idle", 3);

    // T5: async reset mid-job, then a fresh job
    pulse_start(s);
    while (cyc != s + 10) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_async_rst", outs(), 0);
    q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_chk("t5_no_done", 3);
    for (int r = 0; r < ROWS; r++) res_mem[r] = 0;
    load_ramp();
    pulse_start(s);
    wait_q("t5_job", JOB + 10);
    idle_chk("t5_idle", 2);

    // T6: start held high -> back-to-back jobs
    for (int r = 0; r < ROWS; r++) res_mem[r] = 0;
    @(negedge clk);
    start = 1'b1;
    s = cyc + 1;
    push_job(s);
    push_job(s + JOB + 2);
    push_job(s + 2*(JOB + 2));
    repeat (70) @(negedge clk);
    start = 1'b0;
    wait_q("t6_jobs", 3*JOB + 20);
    idle_chk("t6_idle", 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
